// File: rtl/mosfet_gate_guard.sv
// Gate-pin safety stage: per half-bridge interlock, dead time and max on-time,
// plus a latched global fault that holds every gate low until software clears it.

module mgg_ontimer #(
    parameter logic [15:0] MAX_ON_CYCLES = 16'd20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_on,
    output logic o_ot
);
    logic [15:0] r_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_on <= '0;
        else        r_on <= i_on ? r_on + 16'd1 : 16'd0;
    end

    // r_on lags the line by one cycle, so MAX-1 here means this is the MAX-th high cycle
    assign o_ot = i_on && (r_on >= MAX_ON_CYCLES - 16'd1);
endmodule

module mgg_pair #(
    parameter logic [7:0]  DEAD_CYCLES   = 8'd10,
    parameter logic [15:0] MAX_ON_CYCLES = 16'd20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_hold,
    output logic [1:0] o_gate,
    output logic [1:0] o_ot
);
    typedef enum logic [1:0] {IDLE, UP_ON, LO_ON, DEAD} st_t;

    st_t        r_st;
    logic [7:0] r_dcnt;
    logic [1:0] r_gate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st   <= IDLE;
            r_dcnt <= '0;
            r_gate <= '0;
        end else if (i_hold) begin
            r_st   <= DEAD;
            r_dcnt <= DEAD_CYCLES - 8'd1;
            r_gate <= '0;
        end else begin
            case (r_st)
                UP_ON, LO_ON: begin
                    // gate mirrors the accepted request, so any change ends the interval
                    if (i_req != r_gate) begin
                        r_st   <= DEAD;
                        r_dcnt <= DEAD_CYCLES - 8'd1;
                        r_gate <= 2'b00;
                    end
                end
                default: begin
                    if (r_st == DEAD && r_dcnt != 8'd0) begin
                        r_dcnt <= r_dcnt - 8'd1;
                    end else begin
                        case (i_req)
                            2'b10: begin r_st <= UP_ON; r_gate <= 2'b10; end
                            2'b01: begin r_st <= LO_ON; r_gate <= 2'b01; end
                            default: begin r_st <= IDLE; r_gate <= 2'b00; end
                        endcase
                    end
                end
            endcase
        end
    end

    assign o_gate = r_gate;

    for (genvar b = 0; b < 2; b++) begin : g_on
        mgg_ontimer #(.MAX_ON_CYCLES(MAX_ON_CYCLES)) u_on (
            .clk  (clk),
            .rst_n(rst_n),
            .i_on (r_gate[b]),
            .o_ot (o_ot[b])
        );
    end
endmodule

module mosfet_gate_guard #(
    parameter logic [7:0]  DEAD_CYCLES   = 8'd10,
    parameter logic [15:0] MAX_ON_CYCLES = 16'd20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mosfet_buck1_in,
    input  logic [1:0] mosfet_buck2_in,
    input  logic [1:0] mosfet_res1_in,
    input  logic [1:0] mosfet_res2_in,
    input  logic       mosfet_deion_in,
    input  logic       is_operation,
    input  logic       fault_clear,
    output logic [1:0] gate_buck1,
    output logic [1:0] gate_buck2,
    output logic [1:0] gate_res1,
    output logic [1:0] gate_res2,
    output logic       gate_deion,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] fault_chan
);
    localparam int NUM_PAIRS = 4;

    logic [NUM_PAIRS-1:0][1:0] w_raw, w_req, w_gate, w_ot_pair;
    logic [NUM_PAIRS-1:0]      w_st;
    logic [NUM_PAIRS:0]        w_ot;
    logic [1:0]                w_code;
    logic [2:0]                w_chan;
    logic                      w_set, w_clr, w_hold, w_idle_in;

    logic       r_fault, r_deion;
    logic [1:0] r_code;
    logic [2:0] r_chan;

    assign w_raw = {mosfet_res2_in, mosfet_res1_in, mosfet_buck2_in, mosfet_buck1_in};

    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        assign w_st[p]  = &w_raw[p];
        assign w_req[p] = is_operation ? w_raw[p] : 2'b00;
        assign w_ot[p]  = |w_ot_pair[p];
        mgg_pair #(.DEAD_CYCLES(DEAD_CYCLES), .MAX_ON_CYCLES(MAX_ON_CYCLES)) u_pair (
            .clk   (clk),
            .rst_n (rst_n),
            .i_req (w_req[p]),
            .i_hold(w_hold),
            .o_gate(w_gate[p]),
            .o_ot  (w_ot_pair[p])
        );
    end

    mgg_ontimer #(.MAX_ON_CYCLES(MAX_ON_CYCLES)) u_on_deion (
        .clk  (clk),
        .rst_n(rst_n),
        .i_on (r_deion),
        .o_ot (w_ot[NUM_PAIRS])
    );

    // Descending scans so the lowest channel is written last; shoot-through overrides over-time
    always_comb begin
        w_code = 2'd0;
        w_chan = 3'd0;
        for (int c = NUM_PAIRS; c >= 0; c--)
            if (w_ot[c]) begin w_code = 2'd2; w_chan = 3'(c); end
        for (int c = NUM_PAIRS - 1; c >= 0; c--)
            if (w_st[c]) begin w_code = 2'd1; w_chan = 3'(c); end
    end

    assign w_idle_in = ~|w_raw && !mosfet_deion_in;
    assign w_set     = !r_fault && (w_code != 2'd0);
    assign w_clr     = r_fault && fault_clear && w_idle_in;
    assign w_hold    = r_fault || w_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
            r_code  <= '0;
            r_chan  <= '0;
            r_deion <= 1'b0;
        end else begin
            if (w_set) begin
                r_fault <= 1'b1;
                r_code  <= w_code;
                r_chan  <= w_chan;
            end else if (w_clr) begin
                r_fault <= 1'b0;
                r_code  <= '0;
                r_chan  <= '0;
            end
            r_deion <= mosfet_deion_in && is_operation && !w_hold;
        end
    end

    assign gate_buck1 = w_gate[0];
    assign gate_buck2 = w_gate[1];
    assign gate_res1  = w_gate[2];
    assign gate_res2  = w_gate[3];
    assign gate_deion = r_deion;
    assign fault      = r_fault;
    assign fault_code = r_code;
    assign fault_chan = r_chan;
endmodule

// File: tb/tb_mosfet_gate_guard.sv
// Bench for mosfet_gate_guard: vector table, directed timing sequences, random vs. timestamp model.
module tb_mosfet_gate_guard;
    localparam int D   = 10;
    localparam int MAX = 20000;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [1:0] b1, b2, r1, r2;
    logic       dei, op, clr;
    logic [1:0] g_b1, g_b2, g_r1, g_r2, fcode;
    logic       g_dei, flt;
    logic [2:0] fchan;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mosfet_gate_guard dut (
        .clk(clk), .rst_n(rst_n),
        .mosfet_buck1_in(b1), .mosfet_buck2_in(b2), .mosfet_res1_in(r1), .mosfet_res2_in(r2),
        .mosfet_deion_in(dei), .is_operation(op), .fault_clear(clr),
        .gate_buck1(g_b1), .gate_buck2(g_b2), .gate_res1(g_r1), .gate_res2(g_r2),
        .gate_deion(g_dei), .fault(flt), .fault_code(fcode), .fault_chan(fchan)
    );

    function automatic logic [14:0] outs();
        return {g_b1, g_b2, g_r1, g_r2, g_dei, flt, fcode, fchan};
    endfunction

    function automatic logic [14:0] E(input logic [1:0] gb1, gb2, gr1, gr2, input logic gd, f,
                                      input logic [1:0] code, input logic [2:0] chan);
        return {gb1, gb2, gr1, gr2, gd, f, code, chan};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_in();
        b1 = 0; b2 = 0; r1 = 0; r2 = 0; dei = 0; clr = 0; op = 1;
    endtask

    task automatic do_reset();
        zero_in();
        rst_n = 0;
        step(); step();
        chk("reset_outs", outs(), 15'd0);
        rst_n = 1;
        step();
    endtask

    // reference model: per-pair output plus the timestamp of its last forced-low edge
    logic [1:0] m_out[4];
    int         m_ref[4];
    bit         m_refv[4];
    int         m_on[5];
    logic       m_dei;
    bit         m_f;
    int         m_code, m_chan;

    task automatic model_init();
        for (int p = 0; p < 4; p++) begin m_out[p] = 0; m_ref[p] = 0; m_refv[p] = 0; end
        for (int c = 0; c < 5; c++) m_on[c] = 0;
        m_dei = 0; m_f = 0; m_code = 0; m_chan = 0;
    endtask

    task automatic model_edge(input int k);
        logic [1:0] rq[4];
        logic [1:0] r;
        int  code, chan;
        bit  nw;
        rq[0] = b1; rq[1] = b2; rq[2] = r1; rq[3] = r2;
        code = 0; chan = 0;
        for (int c = 4; c >= 0; c--) if (m_on[c] >= MAX) begin code = 2; chan = c; end
        for (int c = 3; c >= 0; c--) if (rq[c] == 2'b11) begin code = 1; chan = c; end
        nw = !m_f && code != 0;
        if (m_f || nw) begin
            for (int p = 0; p < 4; p++) begin m_out[p] = 0; m_ref[p] = k; m_refv[p] = 1; end
            m_dei = 0;
            if (nw) begin m_f = 1; m_code = code; m_chan = chan; end
            else if (clr && {b1, b2, r1, r2, dei} == 9'd0) begin m_f = 0; m_code = 0; m_chan = 0; end
        end else begin
            for (int p = 0; p < 4; p++) begin
                r = op ? rq[p] : 2'b00;
                if (m_out[p] != 0) begin
                    if (r != m_out[p]) begin m_out[p] = 0; m_ref[p] = k; m_refv[p] = 1; end
                end else if ((r == 2'b01 || r == 2'b10) && (!m_refv[p] || k >= m_ref[p] + D)) begin
                    m_out[p] = r;
                end
            end
            m_dei = dei & op;
        end
        for (int p = 0; p < 4; p++) m_on[p] = (m_out[p] != 0) ? m_on[p] + 1 : 0;
        m_on[4] = m_dei ? m_on[4] + 1 : 0;
    endtask

    function automatic logic [14:0] m_exp();
        return {m_out[0], m_out[1], m_out[2], m_out[3], m_dei, m_f, 2'(m_code), 3'(m_chan)};
    endfunction

    typedef struct {
        logic [1:0]  b1, b2, r1, r2;
        logic        dei, op, clr;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cnt, k, zeros;
        logic [1:0] rq[4];

        tbl[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, E(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{2'b00, 2'b00, 2'b10, 2'b00, 1, 1, 0, E(0, 0, 2, 0, 1, 0, 0, 0)};
        tbl[2]  = '{2'b00, 2'b11, 2'b10, 2'b00, 1, 1, 0, E(0, 0, 0, 0, 0, 1, 1, 1)};
        tbl[3]  = '{2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 1, E(0, 0, 0, 0, 0, 1, 1, 1)};
        tbl[4]  = '{2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 0, E(0, 0, 0, 0, 0, 1, 1, 1)};
        tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, E(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{2'b10, 2'b00, 2'b00, 2'b00, 0, 1, 0, E(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, E(0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{2'b11, 2'b00, 2'b00, 2'b11, 0, 1, 0, E(0, 0, 0, 0, 0, 1, 1, 0)};
        tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, E(0, 0, 0, 0, 0, 1, 1, 0)};
        tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, E(0, 0, 0, 0, 0, 0, 0, 0)};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            b1 = tbl[i].b1; b2 = tbl[i].b2; r1 = tbl[i].r1; r2 = tbl[i].r2;
            dei = tbl[i].dei; op = tbl[i].op; clr = tbl[i].clr;
            step();
            chk($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
        end

        // buck1: 50 cycles upper, then lower after exactly D dead cycles
        do_reset();
        b1 = 2'b10; cnt = 0;
        repeat (50) begin step(); if (g_b1 == 2'b10) cnt++; end
        chk("buck1_on50", cnt, 50);
        b1 = 2'b01; cnt = 0; k = 0;
        while (g_b1 != 2'b01 && k < 40) begin step(); k++; if (g_b1 == 2'b00) cnt++; end
        chk("buck1_dead", cnt, D);
        chk("buck1_lo", g_b1, 2'b01);
        chk("buck1_nofault", flt, 0);

        // res2: short low pulse, high side requested mid-dead
        do_reset();
        r2 = 2'b01;
        repeat (3) step();
        chk("res2_lo", g_r2, 2'b01);
        r2 = 2'b00; step(); chk("res2_off", g_r2, 2'b00);
        zeros = 1; step(); if (g_r2 == 2'b00) zeros++;
        r2 = 2'b10; k = 0;
        while (g_r2 != 2'b10 && k < 30) begin step(); k++; if (g_r2 == 2'b00) zeros++; end
        chk("res2_dead", zeros, D);
        chk("res2_hi", g_r2, 2'b10);

        // is_operation drop mid-pulse, then async reset mid-pulse
        do_reset();
        b1 = 2'b10; step();
        chk("op_on", g_b1, 2'b10);
        op = 0; step();
        chk("op_off", g_b1, 2'b00);
        chk("op_nofault", flt, 0);
        op = 1;
        repeat (12) step();
        chk("op_reon", g_b1, 2'b10);
        #2 rst_n = 0;
        #1 chk("async_reset", outs(), 15'd0);
        zero_in(); step(); rst_n = 1; step();

        // deion over-time
        do_reset();
        dei = 1; cnt = 0;
        repeat (20005) begin step(); if (g_dei) cnt++; end
        chk("deion_hi_len", cnt, MAX);
        chk("deion_ot_outs", outs(), E(0, 0, 0, 0, 0, 1, 2, 4));

        // clear rules
        dei = 0; b1 = 2'b10; clr = 1; step();
        chk("clr_ignored", {flt, fcode, fchan}, {1'b1, 2'd2, 3'd4});
        b1 = 2'b00; step();
        chk("clr_done", {flt, fcode, fchan}, 6'd0);
        clr = 0; b1 = 2'b10; k = 0;
        while (g_b1 != 2'b10 && k < 30) begin step(); k++; end
        chk("clr_dead", k, D);

        // random against the model
        do_reset();
        model_init();
        for (int p = 0; p < 4; p++) rq[p] = 0;
        for (int t = 0; t < 3000; t++) begin
            if (m_f && $urandom_range(0, 1) == 1) begin
                for (int p = 0; p < 4; p++) rq[p] = 0;
                dei = 0;
                clr = ($urandom_range(0, 2) == 0);
            end else begin
                for (int p = 0; p < 4; p++) begin
                    if ($urandom_range(0, 9) == 0) begin
                        k = $urandom_range(0, 39);
                        rq[p] = (k == 0) ? 2'b11 : (k < 14) ? 2'b00 : (k < 27) ? 2'b01 : 2'b10;
                    end
                end
                if ($urandom_range(0, 15) == 0) dei = ~dei;
                clr = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 49) == 0) op = ~op;
            b1 = rq[0]; b2 = rq[1]; r1 = rq[2]; r2 = rq[3];
            model_edge(t);
            step();
            chk($sformatf("rand[%0d]", t), outs(), m_exp());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
